ft245_cmd_decoder: RTL and testbench

FT245_CMD_DECODER -- requirements
Module: ft245_cmd_decoder

---
 rtl/ft245_cmd_decoder.sv | 175 +++++++++++++++++
 tb/tb_ft245_cmd_decoder.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ft245_cmd_decoder.sv
// FT245 command decoder: parses 'W' addr data / 'R' addr frames into register
// strobes and answers each frame with a single reply byte ('K', read data or 'E').
module ft245_cmd_decoder #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic [WIDTH-1:0] rx_data_si,
  input  logic             rx_rdy_si,
  output logic             rx_ack_si,
  output logic [WIDTH-1:0] tx_data_si,
  output logic             tx_rdy_si,
  input  logic             tx_ack_si,
  output logic [7:0]       reg_addr,
  output logic [7:0]       reg_wdata,
  output logic             reg_we,
  output logic             reg_re,
  input  logic [7:0]       reg_rdata,
  output logic [15:0]      frame_cnt,
  output logic [7:0]       err_cnt
);

  localparam int unsigned TMO_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  localparam logic [WIDTH-1:0] CMD_W   = WIDTH'(8'h57);
  localparam logic [WIDTH-1:0] CMD_R   = WIDTH'(8'h52);
  localparam logic [WIDTH-1:0] REPLY_K = WIDTH'(8'h4B);
  localparam logic [WIDTH-1:0] REPLY_E = WIDTH'(8'h45);

  typedef enum logic [2:0] {
    IDLE, GET_ADDR, GET_DATA, EXEC, READ_WAIT, SEND
  } state_e;

  state_e           state_q, state_d;
  logic             cmd_wr_q, cmd_wr_d;
  logic             err_frame_q, err_frame_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic [7:0]       addr_q, addr_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [WIDTH-1:0] tx_data_q, tx_data_d;
  logic [15:0]      frame_cnt_q, frame_cnt_d;
  logic [7:0]       err_cnt_q, err_cnt_d;
  logic             err_inc;
  logic             rx_take;

  always_ff @(posedge clk_100M) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_wr_q    <= 1'b0;
      err_frame_q <= 1'b0;
      tmo_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      tx_data_q   <= '0;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      cmd_wr_q    <= cmd_wr_d;
      err_frame_q <= err_frame_d;
      tmo_q       <= tmo_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      tx_data_q   <= tx_data_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign rx_take = rx_ack_si & rx_rdy_si;

  // Next state and datapath; the idle counter is held at zero outside the receive states.
  always_comb begin
    state_d     = state_q;
    cmd_wr_d    = cmd_wr_q;
    err_frame_d = err_frame_q;
    tmo_d       = '0;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    tx_data_d   = tx_data_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (rx_take) begin
          if (rx_data_si == CMD_W) begin
            cmd_wr_d    = 1'b1;
            err_frame_d = 1'b0;
            state_d     = GET_ADDR;
          end else if (rx_data_si == CMD_R) begin
            cmd_wr_d    = 1'b0;
            err_frame_d = 1'b0;
            state_d     = GET_ADDR;
          end else begin
            tx_data_d   = REPLY_E;
            err_frame_d = 1'b1;
            err_inc     = 1'b1;
            state_d     = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (rx_take) begin
          addr_d  = 8'(rx_data_si);
          state_d = cmd_wr_q ? GET_DATA : EXEC;
        end else if (tmo_q == TMO_LAST) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      GET_DATA: begin
        if (rx_take) begin
          wdata_d = 8'(rx_data_si);
          state_d = EXEC;
        end else if (tmo_q == TMO_LAST) begin
          err_inc = 1'b1;
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      EXEC: begin
        if (cmd_wr_q) begin
          tx_data_d = REPLY_K;
          state_d   = SEND;
        end else begin
          state_d = READ_WAIT;
        end
      end
      READ_WAIT: begin
        tx_data_d = WIDTH'(reg_rdata);
        state_d   = SEND;
      end
      SEND: begin
        if (tx_ack_si) begin
          state_d = IDLE;
          if (!err_frame_q) frame_cnt_d = frame_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (err_inc && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  // Handshakes and strobes decoded from the current state, forced low during reset.
  always_comb begin
    rx_ack_si = 1'b0;
    tx_rdy_si = 1'b0;
    reg_we    = 1'b0;
    reg_re    = 1'b0;
    if (!rst) begin
      unique case (state_q)
        IDLE, GET_ADDR, GET_DATA: rx_ack_si = rx_rdy_si;
        EXEC: begin
          reg_we = cmd_wr_q;
          reg_re = ~cmd_wr_q;
        end
        SEND:    tx_rdy_si = 1'b1;
        default: ;
      endcase
    end
  end

  assign tx_data_si = tx_data_q;
  assign reg_addr   = addr_q;
  assign reg_wdata  = wdata_q;
  assign frame_cnt  = frame_cnt_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_ft245_cmd_decoder.sv
// Bench for ft245_cmd_decoder: directed frame table, multi-cycle corner sequences
// and a random frame stream checked against a frame-level model.
module tb_ft245_cmd_decoder;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned TMO   = 16;

  logic             clk_100M = 1'b0;
  logic             rst;
  logic [WIDTH-1:0] rx_data_si;
  logic             rx_rdy_si;
  logic             rx_ack_si;
  logic [WIDTH-1:0] tx_data_si;
  logic             tx_rdy_si;
  logic             tx_ack_si;
  logic [7:0]       reg_addr, reg_wdata, reg_rdata;
  logic             reg_we, reg_re;
  logic [15:0]      frame_cnt;
  logic [7:0]       err_cnt;

  ft245_cmd_decoder #(.WIDTH(WIDTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_100M(clk_100M), .rst(rst),
    .rx_data_si(rx_data_si), .rx_rdy_si(rx_rdy_si), .rx_ack_si(rx_ack_si),
    .tx_data_si(tx_data_si), .tx_rdy_si(tx_rdy_si), .tx_ack_si(tx_ack_si),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re),
    .reg_rdata(reg_rdata), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
  );

  always #5 clk_100M = ~clk_100M;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk_100M) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual 0x%0h required 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Register slave memory and observed-event log, sampled on the falling edge.
  logic [7:0] mem [256];
  logic [7:0] q_reply[$], q_wa[$], q_wd[$], q_ra[$];
  int acc_cyc, we_cyc, re_cyc, rise_cyc;
  logic prev_tx_rdy = 1'b0;
  logic [7:0] prev_tx_data = 8'h00;

  always @(negedge clk_100M) begin
    if (rx_rdy_si && rx_ack_si) acc_cyc = cyc;
    if (reg_we || reg_re) chk("we_re_exclusive", int'(reg_we && reg_re), 0);
    if (reg_we) begin
      q_wa.push_back(reg_addr); q_wd.push_back(reg_wdata);
      we_cyc = cyc; mem[reg_addr] = reg_wdata;
    end
    if (reg_re) begin
      q_ra.push_back(reg_addr); re_cyc = cyc; reg_rdata = mem[reg_addr];
    end
    if (tx_rdy_si && !prev_tx_rdy) rise_cyc = cyc;
    if (tx_rdy_si && prev_tx_rdy) chk("tx_data_stable", int'(tx_data_si), int'(prev_tx_data));
    if (tx_rdy_si) chk("rx_ack_in_send", int'(rx_ack_si), 0);
    if (tx_rdy_si && tx_ack_si) q_reply.push_back(tx_data_si);
    prev_tx_rdy  = (tx_rdy_si === 1'b1);
    prev_tx_data = tx_data_si;
  end

  // Reply consumer: random or immediate acks, or one manual ack on request.
  bit auto_ack = 1'b1;
  bit man_ack  = 1'b0;
  int ack_max  = 3;
  initial begin
    tx_ack_si = 1'b0;
    forever begin
      @(posedge clk_100M); #1;
      tx_ack_si = 1'b0;
      if (tx_rdy_si) begin
        if (auto_ack) tx_ack_si = ($urandom_range(0, ack_max) == 0);
        else if (man_ack) begin tx_ack_si = 1'b1; man_ack = 1'b0; end
      end
    end
  end

  task automatic clear_q();
    q_reply.delete(); q_wa.delete(); q_wd.delete(); q_ra.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    bit done = 1'b0;
    rx_data_si = b;
    rx_rdy_si  = 1'b1;
    while (!done && n < 200) begin
      @(negedge clk_100M);
      done = (rx_ack_si === 1'b1);
      @(posedge clk_100M); #1;
      n++;
    end
    rx_rdy_si = 1'b0;
    if (!done) chk($sformatf("byte_%02h_accepted", b), int'(done), 1);
  endtask

  task automatic wait_reply(input int n, input int bound);
    int t = 0;
    while (q_reply.size() < n && t < bound) begin
      @(negedge clk_100M); t++;
    end
    chk("reply_count", q_reply.size(), n);
    @(posedge clk_100M); #1;
  endtask

  typedef struct {
    string      name;
    int         nb;
    logic [7:0] b0, b1, b2;
    logic [7:0] reply;
    bit         we, re, bad;
  } vec_t;

  function automatic vec_t mk(input string n, input int nb, input logic [7:0] b0, b1, b2,
                              input logic [7:0] rep, input bit we, re, bad);
    vec_t v;
    v.name = n; v.nb = nb; v.b0 = b0; v.b1 = b1; v.b2 = b2;
    v.reply = rep; v.we = we; v.re = re; v.bad = bad;
    return v;
  endfunction

  localparam int NV = 9;
  vec_t vt [NV];
  logic [15:0] exp_frame;
  logic [7:0]  exp_err;
  logic [7:0]  model_mem [256];
  logic [7:0]  stream[$], exp_reply[$], exp_wa[$], exp_wd[$], exp_ra[$];

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  initial begin
    int bad_rdy, bad_ack, bad_dat, t;
    logic [7:0] e0;
    for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h5A;
    reg_rdata = 8'h00;

    vt[0] = mk("write_10_a5", 3, 8'h57, 8'h10, 8'hA5, 8'h4B, 1, 0, 0);
    vt[1] = mk("read_10_a5",  2, 8'h52, 8'h10, 8'h00, 8'hA5, 0, 1, 0);
    vt[2] = mk("write_10_3c", 3, 8'h57, 8'h10, 8'h3C, 8'h4B, 1, 0, 0);
    vt[3] = mk("read_10_3c",  2, 8'h52, 8'h10, 8'h00, 8'h3C, 0, 1, 0);
    vt[4] = mk("bad_00",      1, 8'h00, 8'h00, 8'h00, 8'h45, 0, 0, 1);
    vt[5] = mk("read_55",     2, 8'h52, 8'h55, 8'h00, 8'h0F, 0, 1, 0);
    vt[6] = mk("bad_ff",      1, 8'hFF, 8'h00, 8'h00, 8'h45, 0, 0, 1);
    vt[7] = mk("bad_lower_w", 1, 8'h77, 8'h00, 8'h00, 8'h45, 0, 0, 1);
    vt[8] = mk("write_ff_00", 3, 8'h57, 8'hFF, 8'h00, 8'h4B, 1, 0, 0);

    // Reset state, with a byte already offered
    rst = 1'b1; rx_rdy_si = 1'b1; rx_data_si = 8'h57;
    repeat (3) @(posedge clk_100M);
    @(negedge clk_100M);
    chk("rst_rx_ack", int'(rx_ack_si), 0);
    chk("rst_tx_rdy", int'(tx_rdy_si), 0);
    chk("rst_we_re", int'({reg_we, reg_re}), 0);
    chk("rst_tx_data", int'(tx_data_si), 0);
    chk("rst_addr_wdata", int'({reg_addr, reg_wdata}), 0);
    chk("rst_frame_cnt", int'(frame_cnt), 0);
    chk("rst_err_cnt", int'(err_cnt), 0);
    @(posedge clk_100M); #1;
    rst = 1'b0; rx_rdy_si = 1'b0;
    exp_frame = 16'd0; exp_err = 8'd0;

    // Directed frame table, including handshake latencies
    for (int i = 0; i < NV; i++) begin
      clear_q();
      send_byte(vt[i].b0);
      if (vt[i].nb > 1) send_byte(vt[i].b1);
      if (vt[i].nb > 2) send_byte(vt[i].b2);
      wait_reply(1, 100);
      repeat (2) @(posedge clk_100M); #1;
      chk({vt[i].name, "_reply"}, (q_reply.size() > 0) ? int'(q_reply[0]) : -1, int'(vt[i].reply));
      chk({vt[i].name, "_we_count"}, q_wa.size(), int'(vt[i].we));
      chk({vt[i].name, "_re_count"}, q_ra.size(), int'(vt[i].re));
      if (vt[i].we && q_wa.size() > 0) begin
        chk({vt[i].name, "_waddr"}, int'(q_wa[0]), int'(vt[i].b1));
        chk({vt[i].name, "_wdata"}, int'(q_wd[0]), int'(vt[i].b2));
        chk({vt[i].name, "_lat_we"}, we_cyc - acc_cyc, 1);
        chk({vt[i].name, "_lat_tx"}, rise_cyc - acc_cyc, 2);
      end
      if (vt[i].re && q_ra.size() > 0) begin
        chk({vt[i].name, "_raddr"}, int'(q_ra[0]), int'(vt[i].b1));
        chk({vt[i].name, "_lat_re"}, re_cyc - acc_cyc, 1);
        chk({vt[i].name, "_lat_tx"}, rise_cyc - acc_cyc, 3);
      end
      if (vt[i].bad) begin
        chk({vt[i].name, "_lat_tx"}, rise_cyc - acc_cyc, 1);
        exp_err = sat_inc(exp_err);
      end else begin
        exp_frame = exp_frame + 16'd1;
      end
      chk({vt[i].name, "_frame_cnt"}, int'(frame_cnt), int'(exp_frame));
      chk({vt[i].name, "_err_cnt"}, int'(err_cnt), int'(exp_err));
    end

    // A byte on the last cycle before the timeout wins
    clear_q();
    send_byte(8'h57);
    repeat (15) begin @(posedge clk_100M); #1; end
    send_byte(8'h21);
    send_byte(8'h66);
    wait_reply(1, 100);
    repeat (2) @(posedge clk_100M); #1;
    chk("late_byte_reply", (q_reply.size() > 0) ? int'(q_reply[0]) : -1, 8'h4B);
    chk("late_byte_waddr", (q_wa.size() > 0) ? int'(q_wa[0]) : -1, 8'h21);
    chk("late_byte_err_cnt", int'(err_cnt), int'(exp_err));
    exp_frame = exp_frame + 16'd1;

    // Silence after the address byte times out after 16 idle cycles
    clear_q();
    send_byte(8'h57);
    send_byte(8'h20);
    repeat (15) @(posedge clk_100M);
    @(negedge clk_100M);
    chk("tmo_not_yet", int'(err_cnt), int'(exp_err));
    @(negedge clk_100M);
    exp_err = sat_inc(exp_err);
    chk("tmo_err_cnt", int'(err_cnt), int'(exp_err));
    @(posedge clk_100M); #1;
    repeat (4) @(posedge clk_100M); #1;
    chk("tmo_no_reply", q_reply.size(), 0);
    chk("tmo_no_strobe", q_wa.size() + q_ra.size(), 0);
    send_byte(8'h52);
    send_byte(8'h21);
    wait_reply(1, 100);
    repeat (2) @(posedge clk_100M); #1;
    chk("tmo_next_read", (q_reply.size() > 0) ? int'(q_reply[0]) : -1, 8'h66);
    exp_frame = exp_frame + 16'd1;
    chk("tmo_frame_cnt", int'(frame_cnt), int'(exp_frame));

    // Reply back-pressure with a new byte pending
    clear_q();
    auto_ack = 1'b0;
    send_byte(8'h57); send_byte(8'h30); send_byte(8'h77);
    t = 0;
    while (tx_rdy_si !== 1'b1 && t < 20) begin @(posedge clk_100M); #1; t++; end
    rx_data_si = 8'h52; rx_rdy_si = 1'b1;
    bad_rdy = 0; bad_ack = 0; bad_dat = 0;
    repeat (50) begin
      @(negedge clk_100M);
      if (tx_rdy_si !== 1'b1) bad_rdy++;
      if (rx_ack_si !== 1'b0) bad_ack++;
      if (tx_data_si !== 8'h4B) bad_dat++;
    end
    chk("bp_tx_rdy_lost_cycles", bad_rdy, 0);
    chk("bp_rx_ack_cycles", bad_ack, 0);
    chk("bp_tx_data_bad_cycles", bad_dat, 0);
    @(posedge clk_100M); #1;
    man_ack = 1'b1;
    send_byte(8'h52);
    auto_ack = 1'b1;
    send_byte(8'h30);
    wait_reply(2, 100);
    repeat (2) @(posedge clk_100M); #1;
    chk("bp_write_reply", (q_reply.size() > 0) ? int'(q_reply[0]) : -1, 8'h4B);
    chk("bp_read_reply", (q_reply.size() > 1) ? int'(q_reply[1]) : -1, 8'h77);

    // Reset in the middle of a write frame
    clear_q();
    send_byte(8'h57); send_byte(8'h40);
    rst = 1'b1; rx_rdy_si = 1'b1; rx_data_si = 8'h99;
    @(negedge clk_100M);
    chk("midrst_rx_ack", int'(rx_ack_si), 0);
    @(posedge clk_100M);
    @(negedge clk_100M);
    chk("midrst_outputs", int'({tx_rdy_si, reg_we, reg_re}), 0);
    chk("midrst_addr", int'(reg_addr), 0);
    @(posedge clk_100M); #1;
    rst = 1'b0; rx_rdy_si = 1'b0;
    exp_frame = 16'd0; exp_err = 8'd0;
    chk("midrst_counters", int'({frame_cnt, err_cnt}), 0);
    send_byte(8'h52); send_byte(8'h01);
    wait_reply(1, 100);
    repeat (2) @(posedge clk_100M); #1;
    chk("midrst_read_reply", (q_reply.size() > 0) ? int'(q_reply[0]) : -1, 8'h5B);
    chk("midrst_no_we", q_wa.size(), 0);
    exp_frame = exp_frame + 16'd1;
    chk("midrst_frame_cnt", int'(frame_cnt), int'(exp_frame));

    // Random frame stream against a frame-level model
    clear_q();
    for (int i = 0; i < 256; i++) model_mem[i] = mem[i];
    for (int k = 0; k < 60; k++) begin
      int kind;
      logic [7:0] a, d, b;
      kind = $urandom_range(0, 4);
      a = 8'($urandom); d = 8'($urandom);
      if (kind < 2) begin
        stream.push_back(8'h57); stream.push_back(a); stream.push_back(d);
        model_mem[a] = d;
        exp_reply.push_back(8'h4B); exp_wa.push_back(a); exp_wd.push_back(d);
        exp_frame = exp_frame + 16'd1;
      end else if (kind < 4) begin
        stream.push_back(8'h52); stream.push_back(a);
        exp_reply.push_back(model_mem[a]); exp_ra.push_back(a);
        exp_frame = exp_frame + 16'd1;
      end else begin
        do b = 8'($urandom); while (b == 8'h57 || b == 8'h52);
        stream.push_back(b);
        exp_reply.push_back(8'h45);
        exp_err = sat_inc(exp_err);
      end
    end
    foreach (stream[j]) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk_100M); #1; end
      send_byte(stream[j]);
    end
    wait_reply(exp_reply.size(), 2000);
    repeat (2) @(posedge clk_100M); #1;
    foreach (exp_reply[j])
      chk($sformatf("rand_reply_%0d", j), (j < q_reply.size()) ? int'(q_reply[j]) : -1, int'(exp_reply[j]));
    chk("rand_we_count", q_wa.size(), exp_wa.size());
    foreach (exp_wa[j])
      if (j < q_wa.size()) chk($sformatf("rand_write_%0d", j),
                               int'({q_wa[j], q_wd[j]}), int'({exp_wa[j], exp_wd[j]}));
    chk("rand_re_count", q_ra.size(), exp_ra.size());
    foreach (exp_ra[j])
      if (j < q_ra.size()) chk($sformatf("rand_raddr_%0d", j), int'(q_ra[j]), int'(exp_ra[j]));
    chk("rand_frame_cnt", int'(frame_cnt), int'(exp_frame));
    chk("rand_err_cnt", int'(err_cnt), int'(exp_err));

    // Error counter saturation
    clear_q();
    ack_max = 0;
    e0 = exp_err;
    for (int k = 0; k < 260; k++) begin
      send_byte(8'h00);
      e0 = sat_inc(e0);
    end
    wait_reply(260, 2000);
    repeat (2) @(posedge clk_100M); #1;
    chk("sat_err_cnt", int'(err_cnt), int'(e0));
    chk("sat_frame_cnt", int'(frame_cnt), int'(exp_frame));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
